// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-ported Mem between instruction fetch and the LSU.
// LSU wins contention unless fetch has lost STARVE_LIMIT decisions in a row.
module mem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        ls_req,
  input  logic        ls_we,
  input  logic [2:0]  ls_funct3,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  output logic        ls_gnt,
  output logic        ls_rvalid,
  output logic [31:0] ls_rdata,
  output logic        mem_re,
  output logic        mem_we,
  output logic [2:0]  mem_funct3,
  output logic [31:0] mem_raddr,
  output logic [31:0] mem_waddr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [3:0] LIM = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESP} state_t;

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_starve, w_starve_nxt;
  logic        w_if_win, w_ls_win;

  logic        r_if_gnt, r_ls_gnt, r_if_rv, r_ls_rv, r_store;
  logic        r_mem_re, r_mem_we;
  logic [2:0]  r_funct3;
  logic [31:0] r_raddr, r_waddr, r_wdata;

  always_comb begin
    w_state_nxt  = r_state;
    w_starve_nxt = r_starve;
    w_if_win     = 1'b0;
    w_ls_win     = 1'b0;
    case (r_state)
      S_ISSUE: w_state_nxt = S_RESP;
      default: begin
        // IDLE and RESP both arbitrate, so back-to-back accesses need no bubble
        w_if_win    = if_req && (!ls_req || (r_starve == LIM));
        w_ls_win    = ls_req && !w_if_win;
        w_state_nxt = (w_if_win || w_ls_win) ? S_ISSUE : S_IDLE;
        if (if_req && w_ls_win)
          w_starve_nxt = (r_starve == LIM) ? LIM : r_starve + 4'd1;
        else
          w_starve_nxt = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_starve <= 4'd0;
      r_if_gnt <= 1'b0;
      r_ls_gnt <= 1'b0;
      r_if_rv  <= 1'b0;
      r_ls_rv  <= 1'b0;
      r_store  <= 1'b0;
      r_mem_re <= 1'b0;
      r_mem_we <= 1'b0;
      r_funct3 <= 3'd0;
      r_raddr  <= 32'd0;
      r_waddr  <= 32'd0;
      r_wdata  <= 32'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_starve <= w_starve_nxt;
      r_if_gnt <= w_if_win;
      r_ls_gnt <= w_ls_win;
      // rvalid follows gnt by one cycle; a reset during ISSUE kills both
      r_if_rv  <= r_if_gnt;
      r_ls_rv  <= r_ls_gnt;
      r_mem_re <= w_if_win || (w_ls_win && !ls_we);
      r_mem_we <= w_ls_win && ls_we;
      if (w_if_win) begin
        r_funct3 <= 3'b010;
        r_raddr  <= if_addr;
        r_store  <= 1'b0;
      end else if (w_ls_win) begin
        r_funct3 <= ls_funct3;
        r_store  <= ls_we;
        if (ls_we) begin
          r_waddr <= ls_addr;
          r_wdata <= ls_wdata;
        end else begin
          r_raddr <= ls_addr;
        end
      end
    end
  end

  assign if_gnt     = r_if_gnt;
  assign ls_gnt     = r_ls_gnt;
  assign if_rvalid  = r_if_rv;
  assign ls_rvalid  = r_ls_rv;
  assign if_rdata   = r_if_rv ? mem_rdata : 32'd0;
  assign ls_rdata   = (r_ls_rv && !r_store) ? mem_rdata : 32'd0;
  assign mem_re     = r_mem_re;
  assign mem_we     = r_mem_we;
  assign mem_funct3 = r_funct3;
  assign mem_raddr  = r_raddr;
  assign mem_waddr  = r_waddr;
  assign mem_wdata  = r_wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Random and directed bench for mem_port_arbiter against a transaction-level
// model: a decision is made whenever the port was not issuing last cycle.
module tb_mem_port_arbiter;
  localparam int LIMIT = 4;

  logic        clk = 1'b0, reset = 1'b0;
  logic        if_req = 1'b0, ls_req = 1'b0, ls_we = 1'b0;
  logic [31:0] if_addr = '0, ls_addr = '0, ls_wdata = '0;
  logic [2:0]  ls_funct3 = '0;
  logic        if_gnt, if_rvalid, ls_gnt, ls_rvalid, mem_re, mem_we;
  logic [31:0] if_rdata, ls_rdata, mem_raddr, mem_waddr, mem_wdata;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_rdata;

  mem_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_funct3(ls_funct3),
    .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_gnt(ls_gnt),
    .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
    .mem_re(mem_re), .mem_we(mem_we), .mem_funct3(mem_funct3),
    .mem_raddr(mem_raddr), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(int i);
    return (i == 4) ? 32'h0050_0093 : (32'(i) * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
  endfunction

  // Mem: synchronous write, read data registered one cycle after mem_re
  logic [31:0] tmem [256];
  bit          tvld [256];
  always @(posedge clk) begin
    if (mem_we) begin
      tmem[mem_waddr[9:2]] <= mem_wdata;
      tvld[mem_waddr[9:2]] <= 1'b1;
    end
    if (mem_re)
      mem_rdata <= tvld[mem_raddr[9:2]] ? tmem[mem_raddr[9:2]] : init_word(int'(mem_raddr[9:2]));
    else
      mem_rdata <= $urandom;
  end

  int checks = 0, failures = 0, cyc = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // model state: 0 none, 1 fetch, 2 LSU
  int          cur_gnt = 0, cur_rv = 0, starve = 0;
  logic [31:0] cur_rdata = '0, g_addr = '0, g_wdata = '0;
  logic [2:0]  g_f3 = '0;
  logic        g_st = 1'b0;
  logic [31:0] ref_mem [256];

  bit if_pend = 0, ls_pend = 0;
  int p_if = 0, p_ls = 0;
  int gnt_log[$], gnt_cyc[$];
  int exp_seq[10] = '{2, 2, 2, 2, 1, 2, 2, 2, 2, 1};

  function automatic logic [31:0] rand_addr();
    return {22'd0, 8'($urandom_range(255)), 2'b00};
  endfunction

  task automatic chk_zero(input string pfx);
    chk({pfx, "_if_gnt"}, 32'(if_gnt), 0);
    chk({pfx, "_if_rvalid"}, 32'(if_rvalid), 0);
    chk({pfx, "_if_rdata"}, if_rdata, 0);
    chk({pfx, "_ls_gnt"}, 32'(ls_gnt), 0);
    chk({pfx, "_ls_rvalid"}, 32'(ls_rvalid), 0);
    chk({pfx, "_ls_rdata"}, ls_rdata, 0);
    chk({pfx, "_mem_re"}, 32'(mem_re), 0);
    chk({pfx, "_mem_we"}, 32'(mem_we), 0);
    chk({pfx, "_mem_funct3"}, 32'(mem_funct3), 0);
    chk({pfx, "_mem_raddr"}, mem_raddr, 0);
    chk({pfx, "_mem_waddr"}, mem_waddr, 0);
    chk({pfx, "_mem_wdata"}, mem_wdata, 0);
  endtask

  task automatic check_cycle();
    @(negedge clk);
    cyc++;
    chk("if_gnt", 32'(if_gnt), 32'(cur_gnt == 1));
    chk("ls_gnt", 32'(ls_gnt), 32'(cur_gnt == 2));
    chk("if_rvalid", 32'(if_rvalid), 32'(cur_rv == 1));
    chk("ls_rvalid", 32'(ls_rvalid), 32'(cur_rv == 2));
    chk("if_rdata", if_rdata, (cur_rv == 1) ? cur_rdata : 32'd0);
    chk("ls_rdata", ls_rdata, (cur_rv == 2) ? cur_rdata : 32'd0);
    chk("mem_re", 32'(mem_re), 32'(cur_gnt != 0 && !g_st));
    chk("mem_we", 32'(mem_we), 32'(cur_gnt == 2 && g_st));
    if (cur_gnt != 0) begin
      chk("mem_funct3", 32'(mem_funct3), 32'(g_f3));
      if (g_st) begin
        chk("mem_waddr", mem_waddr, g_addr);
        chk("mem_wdata", mem_wdata, g_wdata);
      end else begin
        chk("mem_raddr", mem_raddr, g_addr);
      end
    end
    if (if_gnt) begin gnt_log.push_back(1); gnt_cyc.push_back(cyc); end
    if (ls_gnt) begin gnt_log.push_back(2); gnt_cyc.push_back(cyc); end
  endtask

  task automatic advance();
    int n_gnt;
    int n_rv;
    logic [31:0] n_rdata;
    if (cur_gnt == 1) if_pend = 0;
    if (cur_gnt == 2) ls_pend = 0;
    if (!if_pend && int'($urandom_range(99)) < p_if) begin
      if_pend = 1; if_addr = rand_addr();
    end
    if (!ls_pend && int'($urandom_range(99)) < p_ls) begin
      ls_pend = 1; ls_we = 1'($urandom_range(1)); ls_funct3 = 3'($urandom_range(7));
      ls_addr = rand_addr(); ls_wdata = $urandom;
    end
    if_req = if_pend;
    ls_req = ls_pend;
    // the access granted now completes next cycle
    n_rv = cur_gnt;
    n_rdata = (cur_gnt != 0 && !g_st) ? ref_mem[g_addr[9:2]] : 32'd0;
    if (cur_gnt == 2 && g_st) ref_mem[g_addr[9:2]] = g_wdata;
    n_gnt = 0;
    if (cur_gnt == 0) begin
      if (if_req && (!ls_req || starve == LIMIT)) n_gnt = 1;
      else if (ls_req) n_gnt = 2;
      starve = (if_req && n_gnt == 2) ? ((starve + 1 > LIMIT) ? LIMIT : starve + 1) : 0;
      if (n_gnt == 1) begin
        g_addr = if_addr; g_st = 1'b0; g_f3 = 3'b010;
      end else if (n_gnt == 2) begin
        g_addr = ls_addr; g_st = ls_we; g_f3 = ls_funct3; g_wdata = ls_wdata;
      end
    end
    cur_gnt = n_gnt; cur_rv = n_rv; cur_rdata = n_rdata;
  endtask

  task automatic run(input int n);
    repeat (n) begin advance(); check_cycle(); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    #2 reset = 1'b1;
    #1 chk_zero("rst");
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk_zero("rst_rel");
    run(2);

    // lone fetch
    if_pend = 1; if_addr = 32'h10;
    run(1);
    chk("lone_gnt", 32'(if_gnt), 1);
    chk("lone_raddr", mem_raddr, 32'h10);
    run(1);
    chk("lone_rvalid", 32'(if_rvalid), 1);
    chk("lone_rdata", if_rdata, 32'h0050_0093);
    run(2);

    // store then load at 0x100
    ls_pend = 1; ls_we = 1'b1; ls_addr = 32'h100; ls_wdata = 32'hDEAD_BEEF; ls_funct3 = 3'b010;
    run(1);
    chk("st_we", 32'(mem_we), 1);
    chk("st_re", 32'(mem_re), 0);
    chk("st_waddr", mem_waddr, 32'h100);
    run(1);
    chk("st_rvalid", 32'(ls_rvalid), 1);
    chk("st_rdata", ls_rdata, 0);
    ls_pend = 1; ls_we = 1'b0; ls_addr = 32'h100;
    run(1);
    chk("ld_gnt", 32'(ls_gnt), 1);
    run(1);
    chk("ld_rdata", ls_rdata, 32'hDEAD_BEEF);
    run(3);

    // simultaneous first requests, only fetch persists
    gnt_log.delete(); gnt_cyc.delete();
    if_pend = 1; if_addr = rand_addr();
    ls_pend = 1; ls_we = 1'b0; ls_addr = rand_addr(); ls_funct3 = 3'b100;
    run(5);
    chk("sim_n", 32'(gnt_log.size()), 2);
    if (gnt_log.size() == 2) begin
      chk("sim_first", 32'(gnt_log[0]), 2);
      chk("sim_second", 32'(gnt_log[1]), 1);
      chk("sim_gap", 32'(gnt_cyc[1] - gnt_cyc[0]), 2);
    end
    run(2);

    // sustained contention
    gnt_log.delete(); gnt_cyc.delete();
    p_if = 100; p_ls = 100;
    run(20);
    chk("cont_n", 32'(gnt_log.size()), 10);
    for (int i = 0; i < 10; i++) begin
      if (i < gnt_log.size()) chk($sformatf("cont_seq%0d", i), 32'(gnt_log[i]), 32'(exp_seq[i]));
      if (i > 0 && i < gnt_cyc.size()) chk($sformatf("cont_gap%0d", i), 32'(gnt_cyc[i] - gnt_cyc[i-1]), 2);
    end
    p_if = 0; p_ls = 0;
    run(8);

    // reset during ISSUE of a fetch
    if_pend = 1; if_addr = rand_addr();
    run(1);
    chk("mid_gnt", 32'(if_gnt), 1);
    #1 reset = 1'b1;
    #1 chk_zero("mid_rst");
    cur_gnt = 0; cur_rv = 0; starve = 0;
    if_pend = 0; ls_pend = 0; if_req = 1'b0; ls_req = 1'b0;
    #1 reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      run(1);
      chk("mid_no_rvalid", 32'(if_rvalid), 0);
    end
    if_pend = 1; if_addr = 32'h10;
    run(1);
    chk("post_gnt", 32'(if_gnt), 1);
    run(1);
    chk("post_rvalid", 32'(if_rvalid), 1);
    chk("post_rdata", if_rdata, 32'h0050_0093);

    // random traffic
    p_if = 40; p_ls = 50;
    run(400);
    p_if = 0; p_ls = 0;
    run(12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
